// File: rtl/instruction_prefetch.sv
// Instruction prefetch: fetches aligned 16-bit code words at CS:fetch_offset into a byte FIFO.
// Optional macro PREFETCH_BYPASS_EN presents ack data combinationally when the FIFO is empty.
module instruction_prefetch #(
   parameter int unsigned FIFO_DEPTH = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] cs,
   input  logic [15:0] new_ip,
   input  logic        load_new_ip,
   output logic        mem_access,
   input  logic        mem_ack,
   output logic [18:0] mem_address,
   input  logic [15:0] mem_data,
   input  logic        fifo_rd_en,
   output logic [7:0]  fifo_rd_data,
   output logic        fifo_empty
);

   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic {IDLE, REQ} state_t;

   state_t         state_q, state_d;
   logic [15:0]    fetch_offset_q, fetch_offset_d;
   logic           discard_q, discard_d;
   logic [CW-1:0]  count_q, count_d;
   logic [PW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, wr_ptr_1;
   logic [18:0]    mem_address_q, mem_address_d;
   logic [7:0]     buf_q [FIFO_DEPTH];

   logic           accept, bypass, pop_direct, pop_buf;
   logic [1:0]     n_bytes, wr_n;
   logic [7:0]     first_b, second_b, wr_byte0;
   logic [CW-1:0]  need;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // (cs<<4 + off)>>1 == (cs<<3) + (off>>1) because cs<<4 is even; 19-bit wrap equals 20-bit wrap.
   function automatic logic [18:0] word_addr(input logic [15:0] seg, input logic [14:0] off_hi);
      return {seg, 3'b000} + {4'b0000, off_hi};
   endfunction

   always_comb begin
      accept     = (state_q == REQ) && mem_ack && !discard_q && !load_new_ip;
      first_b    = fetch_offset_q[0] ? mem_data[15:8] : mem_data[7:0];
      second_b   = mem_data[15:8];
      n_bytes    = fetch_offset_q[0] ? 2'd1 : 2'd2;
`ifdef PREFETCH_BYPASS_EN
      bypass     = accept && (count_q == '0);
`else
      bypass     = 1'b0;
`endif
      pop_direct = bypass && fifo_rd_en;
      pop_buf    = fifo_rd_en && (count_q != '0) && !load_new_ip;
      wr_byte0   = pop_direct ? second_b : first_b;
      wr_n       = accept ? (n_bytes - {1'b0, pop_direct}) : 2'd0;
      wr_ptr_1   = ptr_inc(wr_ptr_q);

      fifo_empty   = (count_q == '0) && !bypass;
      fifo_rd_data = bypass ? first_b : ((count_q == '0) ? '0 : buf_q[rd_ptr_q]);
      mem_access   = (state_q == REQ);
      mem_address  = mem_address_q;

      state_d        = state_q;
      fetch_offset_d = fetch_offset_q;
      discard_d      = discard_q;
      mem_address_d  = mem_address_q;
      count_d        = count_q + CW'(wr_n) - CW'(pop_buf);
      rd_ptr_d       = pop_buf ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      wr_ptr_d       = (wr_n == 2'd2) ? ptr_inc(wr_ptr_1) :
                       (wr_n == 2'd1) ? wr_ptr_1 : wr_ptr_q;
      need           = fetch_offset_q[0] ? CW'(1) : CW'(2);

      case (state_q)
         IDLE: begin
            if (load_new_ip) begin
               state_d       = REQ;
               mem_address_d = word_addr(cs, new_ip[15:1]);
            end else if ((DEPTH_C - count_d) >= need) begin
               state_d       = REQ;
               mem_address_d = word_addr(cs, fetch_offset_q[15:1]);
            end
         end
         REQ: begin
            if (mem_ack) begin
               state_d   = IDLE;
               discard_d = 1'b0;
               if (accept)
                  fetch_offset_d = fetch_offset_q + (fetch_offset_q[0] ? 16'd1 : 16'd2);
            end else if (load_new_ip) begin
               discard_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Flush overrides any pop/push bookkeeping computed above.
      if (load_new_ip) begin
         count_d        = '0;
         rd_ptr_d       = '0;
         wr_ptr_d       = '0;
         fetch_offset_d = new_ip;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         fetch_offset_q <= '0;
         discard_q      <= 1'b0;
         count_q        <= '0;
         rd_ptr_q       <= '0;
         wr_ptr_q       <= '0;
         mem_address_q  <= '0;
      end else begin
         state_q        <= state_d;
         fetch_offset_q <= fetch_offset_d;
         discard_q      <= discard_d;
         count_q        <= count_d;
         rd_ptr_q       <= rd_ptr_d;
         wr_ptr_q       <= wr_ptr_d;
         mem_address_q  <= mem_address_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_n != 2'd0) buf_q[wr_ptr_q] <= wr_byte0;
      if (wr_n == 2'd2) buf_q[wr_ptr_1] <= second_b;
   end

endmodule

// File: tb/tb_instruction_prefetch.sv
// Directed bench for instruction_prefetch (default build, FIFO_DEPTH=6).
module tb_instruction_prefetch;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] cs, new_ip, mem_data;
   logic        load_new_ip, mem_ack, fifo_rd_en;
   logic        mem_access, fifo_empty;
   logic [18:0] mem_address;
   logic [7:0]  fifo_rd_data;
   int          total = 0;
   int          bad = 0;

   instruction_prefetch #(.FIFO_DEPTH(6)) dut (
      .clk(clk), .reset(reset), .cs(cs), .new_ip(new_ip), .load_new_ip(load_new_ip),
      .mem_access(mem_access), .mem_ack(mem_ack), .mem_address(mem_address),
      .mem_data(mem_data), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
      .fifo_empty(fifo_empty)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ack(input logic [15:0] d);
      mem_ack = 1'b1; mem_data = d;
      tick();
      mem_ack = 1'b0;
   endtask

   task automatic load(input logic [15:0] ip);
      load_new_ip = 1'b1; new_ip = ip;
      tick();
      load_new_ip = 1'b0;
   endtask

   task automatic pop();
      fifo_rd_en = 1'b1;
      tick();
      fifo_rd_en = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [7:0] exp_b [5];
      exp_b[0] = 8'h04; exp_b[1] = 8'h05; exp_b[2] = 8'h06; exp_b[3] = 8'h07; exp_b[4] = 8'h08;
      reset = 1'b1; cs = 16'h1000; new_ip = '0; mem_data = '0;
      load_new_ip = 1'b0; mem_ack = 1'b0; fifo_rd_en = 1'b0;
      #2;
      check("rst_access", mem_access, 0);
      check("rst_addr", mem_address, 0);
      check("rst_empty", fifo_empty, 1);
      check("rst_rdata", fifo_rd_data, 0);
      tick(); tick();
      reset = 1'b0;
      tick();
      check("boot_access", mem_access, 1);
      check("boot_addr", mem_address, 19'h08000);

      ack(16'h2211);
      check("boot_empty", fifo_empty, 0);
      check("boot_rdata", fifo_rd_data, 8'h11);
      check("idle_gap", mem_access, 0);

      // Test 1: branch to 0x0100 from IDLE
      load(16'h0100);
      check("t1_access", mem_access, 1);
      check("t1_addr", mem_address, 19'h08080);
      check("t1_flushed", fifo_empty, 1);
      ack(16'hBBAA);
      check("t1_empty", fifo_empty, 0);
      check("t1_b0", fifo_rd_data, 8'hAA);
      pop();
      check("t1_b1", fifo_rd_data, 8'hBB);
      check("t1_next_access", mem_access, 1);
      check("t1_next_addr", mem_address, 19'h08081);
      pop();
      check("t1_drained", fifo_empty, 1);
      check("t1_drained_rdata", fifo_rd_data, 0);

      // Test 4: flush while a request is outstanding
      load(16'h0200);
      check("t4_hold_access", mem_access, 1);
      check("t4_hold_addr", mem_address, 19'h08081);
      ack(16'h1234);
      check("t4_stale_empty", fifo_empty, 1);
      check("t4_stale_idle", mem_access, 0);
      tick();
      check("t4_reissue", mem_access, 1);
      check("t4_addr", mem_address, 19'h08100);
      ack(16'h5678);
      check("t4_b0", fifo_rd_data, 8'h78);
      pop();
      check("t4_b1", fifo_rd_data, 8'h56);
      pop();
      check("t4_drained", fifo_empty, 1);

      // Test 2: odd branch target pushes only the high byte
      ack(16'h0000);
      load(16'h0101);
      check("t2_addr", mem_address, 19'h08080);
      check("t2_flushed", fifo_empty, 1);
      ack(16'hBBAA);
      check("t2_b", fifo_rd_data, 8'hBB);
      tick();
      check("t2_next_access", mem_access, 1);
      check("t2_next_addr", mem_address, 19'h08081);
      pop();
      check("t2_one_byte", fifo_empty, 1);

      // Test 3: fill to depth, then issue only once two slots free
      ack(16'h0201); tick();
      check("t3_addr2", mem_address, 19'h08082);
      ack(16'h0403); tick();
      ack(16'h0605);
      tick(); tick(); tick();
      check("t3_full_stall", mem_access, 0);
      check("t3_head", fifo_rd_data, 8'h01);
      pop();
      check("t3_one_free", mem_access, 0);
      check("t3_head2", fifo_rd_data, 8'h02);
      tick();
      check("t3_still_stall", mem_access, 0);
      pop();
      check("t3_issue", mem_access, 1);
      check("t3_issue_addr", mem_address, 19'h08084);
      check("t3_head3", fifo_rd_data, 8'h03);

      // Test 6: pop on the ack cycle of a 2-byte fetch with count=4
      mem_ack = 1'b1; mem_data = 16'h0807; fifo_rd_en = 1'b1;
      tick();
      mem_ack = 1'b0; fifo_rd_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("t6_byte%0d", i), fifo_rd_data, exp_b[i]);
         pop();
      end
      check("t6_count5", fifo_empty, 1);

      // Reset asserted mid-request
      ack(16'h0A09); tick();
      check("rstmid_pre_access", mem_access, 1);
      check("rstmid_pre_empty", fifo_empty, 0);
      reset = 1'b1;
      #1;
      check("rstmid_access", mem_access, 0);
      check("rstmid_empty", fifo_empty, 1);
      check("rstmid_addr", mem_address, 0);

      // Test 5: offset wrap and 20-bit physical wrap
      cs = 16'h0000;
      tick();
      reset = 1'b0;
      tick();
      check("t5_boot_addr", mem_address, 19'h00000);
      ack(16'h1111);
      load(16'hFFFF);
      check("t5_top_addr", mem_address, 19'h07FFF);
      ack(16'hCCDD);
      check("t5_hi_byte", fifo_rd_data, 8'hCC);
      tick();
      check("t5_wrap_access", mem_access, 1);
      check("t5_wrap_addr", mem_address, 19'h00000);
      pop();
      check("t5_single", fifo_empty, 1);
      cs = 16'hFFFF;
      ack(16'h0000);
      load(16'h0010);
      check("t5_phys_wrap", mem_address, 19'h00000);
      ack(16'h4433);
      check("t5_pw_byte", fifo_rd_data, 8'h33);
      tick();
      check("t5_pw_next", mem_address, 19'h00001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
